// File: rtl/rtp_header_inserter_pkg.sv
// Shared types and helpers for the RTP header inserter.
// RTP header words are built here so the byte order lives in one place.
`timescale 1ns/1ps
package rtp_header_inserter_pkg;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DRAIN} hdr_state_t;

    typedef struct packed {
        logic [31:0] timestamp;
        logic        marker;
        logic [15:0] length;
        logic        field;
        logic [14:0] line;
        logic [14:0] offset;
    } rtp_desc_t;

    localparam logic [7:0] RTP_VERSION_BYTE = 8'h80;
    localparam int         HDR_WORDS        = 5;

    function automatic logic [2:0] popcount4(input logic [3:0] k);
        return {2'b00, k[0]} + {2'b00, k[1]} + {2'b00, k[2]} + {2'b00, k[3]};
    endfunction

    // Lane 0 ([7:0]) carries the first wire byte, so big-endian fields are byte-reversed.
    function automatic logic [31:0] hdr_word(input logic [2:0] idx, input rtp_desc_t d,
                                             input logic [31:0] seq, input logic [31:0] ssrc,
                                             input logic [6:0] pt);
        logic [31:0] w;
        case (idx)
            3'd0:    w = {seq[7:0], seq[15:8], d.marker, pt, RTP_VERSION_BYTE};
            3'd1:    w = {d.timestamp[7:0], d.timestamp[15:8], d.timestamp[23:16], d.timestamp[31:24]};
            3'd2:    w = {ssrc[7:0], ssrc[15:8], ssrc[23:16], ssrc[31:24]};
            3'd3:    w = {d.length[7:0], d.length[15:8], seq[23:16], seq[31:24]};
            default: w = {d.offset[7:0], 1'b0, d.offset[14:8], d.line[7:0], d.field, d.line[14:8]};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rtp_header_inserter_out_reg.sv
// Single-entry AXI-Stream output register; contents hold while stalled.
`timescale 1ns/1ps
module rtp_out_reg (
    input  logic        aclk,
    input  logic        areset,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [3:0]  keep,
    input  logic        last,
    output logic        slot_free,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tlast
);

    assign slot_free = !m_axis_tvalid || m_axis_tready;

    // load is only raised by the caller when slot_free is true.
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= data;
            m_axis_tkeep  <= keep;
            m_axis_tlast  <= last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/rtp_header_inserter.sv
// Prepends RTP + RFC 4175 payload headers to a 32-bit payload stream,
// owns the extended sequence counter and flags oversize/length errors.
`timescale 1ns/1ps
module rtp_header_inserter
    import rtp_header_inserter_pkg::*;
#(
    parameter logic [31:0] SSRC_ID           = 32'd0,
    parameter logic [6:0]  PAYLOAD_TYPE      = 7'd96,
    parameter int          MAX_PAYLOAD_WORDS = 2231
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        seq_load,
    input  logic [31:0] seq_init,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [31:0] hdr_timestamp,
    input  logic        hdr_marker,
    input  logic [15:0] hdr_length,
    input  logic        hdr_field,
    input  logic [14:0] hdr_line,
    input  logic [14:0] hdr_offset,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic [31:0] stat_pkt_count,
    output logic        err_len,
    output logic        err_oversize
);

    localparam logic [15:0] LAST_IDX = 16'(MAX_PAYLOAD_WORDS - 1);

    hdr_state_t  state, state_nxt;
    rtp_desc_t   desc;
    logic [2:0]  hdr_idx;
    logic [15:0] wcnt;
    logic [31:0] seq;
    logic        slot_free, load, ld_last;
    logic [31:0] ld_data;
    logic [3:0]  ld_keep;
    logic        pay_acc, at_max, pkt_end;
    logic [17:0] byte_cnt;

    assign pay_acc  = (state == PAYLOAD) && s_axis_tvalid && slot_free;
    assign at_max   = (wcnt == LAST_IDX);
    assign pkt_end  = pay_acc && (s_axis_tlast || at_max);
    // wcnt counts beats before the current one, so this is 4*(beats-1) + popcount.
    assign byte_cnt = {wcnt, 2'b00} + 18'(popcount4(s_axis_tkeep));

    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hdr_valid) state_nxt = HDR;
            HDR:     if (slot_free && hdr_idx == 3'(HDR_WORDS - 1)) state_nxt = PAYLOAD;
            PAYLOAD: if (pay_acc && s_axis_tlast) state_nxt = IDLE;
                     else if (pay_acc && at_max)  state_nxt = DRAIN;
            DRAIN:   if (s_axis_tvalid && s_axis_tlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        hdr_ready     = 1'b0;
        s_axis_tready = 1'b0;
        load          = 1'b0;
        ld_data       = '0;
        ld_keep       = '0;
        ld_last       = 1'b0;
        if (!areset) begin
            case (state)
                IDLE: hdr_ready = 1'b1;
                HDR: begin
                    load    = slot_free;
                    ld_data = hdr_word(hdr_idx, desc, seq, SSRC_ID, PAYLOAD_TYPE);
                    ld_keep = 4'hF;
                end
                PAYLOAD: begin
                    s_axis_tready = slot_free;
                    load          = pay_acc;
                    ld_data       = s_axis_tdata;
                    ld_keep       = s_axis_tkeep;
                    ld_last       = s_axis_tlast || at_max;
                end
                DRAIN:   s_axis_tready = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            desc           <= '0;
            hdr_idx        <= '0;
            wcnt           <= '0;
            seq            <= '0;
            stat_pkt_count <= '0;
            err_len        <= 1'b0;
            err_oversize   <= 1'b0;
        end else begin
            err_len      <= pay_acc && s_axis_tlast && (byte_cnt != {2'b00, desc.length});
            err_oversize <= pay_acc && !s_axis_tlast && at_max;
            if (state == IDLE && hdr_valid) begin
                desc    <= '{timestamp: hdr_timestamp, marker: hdr_marker, length: hdr_length,
                             field: hdr_field, line: hdr_line, offset: hdr_offset};
                hdr_idx <= '0;
                wcnt    <= '0;
            end
            if (state == HDR && slot_free) hdr_idx <= hdr_idx + 3'd1;
            if (pay_acc) wcnt <= wcnt + 16'd1;
            // A load in the same cycle as a packet end wins; earlier header words keep the old value.
            if (seq_load)     seq <= seq_init;
            else if (pkt_end) seq <= seq + 32'd1;
            if (pkt_end) stat_pkt_count <= stat_pkt_count + 32'd1;
        end
    end

    rtp_out_reg u_out (
        .aclk          (aclk),
        .areset        (areset),
        .load          (load),
        .data          (ld_data),
        .keep          (ld_keep),
        .last          (ld_last),
        .slot_free     (slot_free),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast)
    );

endmodule

// File: tb/tb_rtp_header_inserter.sv
// Scoreboard bench: unit 0 uses the default payload limit, unit 1 a limit of 4 words.
`timescale 1ns/1ps
module tb_rtp_header_inserter;

    localparam int BOUND = 2000;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        areset, seq_load, m_tready, s_tlast, hdr_marker, hdr_field;
    logic [31:0] seq_init, hdr_timestamp, s_tdata;
    logic [15:0] hdr_length;
    logic [14:0] hdr_line, hdr_offset;
    logic [3:0]  s_tkeep;
    logic        hdr_valid [2];
    logic        s_tvalid  [2];
    logic        hdr_ready [2];
    logic        s_tready  [2];
    logic        m_tvalid  [2];
    logic        m_tlast   [2];
    logic        err_len   [2];
    logic        err_ovs   [2];
    logic [31:0] m_tdata   [2];
    logic [3:0]  m_tkeep   [2];
    logic [31:0] stat      [2];

    int          checks = 0, errors = 0;
    logic [36:0] q0[$], q1[$];
    logic [31:0] mseq     [2];
    int          elen_cnt [2];
    int          eovs_cnt [2];
    logic        tl_prev  [2];
    bit          bp_en = 0;

    rtp_header_inserter #(.SSRC_ID(32'hCAFEF00D)) dut0 (
        .aclk(aclk), .areset(areset), .seq_load(seq_load), .seq_init(seq_init),
        .hdr_valid(hdr_valid[0]), .hdr_ready(hdr_ready[0]), .hdr_timestamp(hdr_timestamp),
        .hdr_marker(hdr_marker), .hdr_length(hdr_length), .hdr_field(hdr_field),
        .hdr_line(hdr_line), .hdr_offset(hdr_offset),
        .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]), .s_axis_tlast(s_tlast),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]),
        .stat_pkt_count(stat[0]), .err_len(err_len[0]), .err_oversize(err_ovs[0]));

    rtp_header_inserter #(.MAX_PAYLOAD_WORDS(4)) dut1 (
        .aclk(aclk), .areset(areset), .seq_load(seq_load), .seq_init(seq_init),
        .hdr_valid(hdr_valid[1]), .hdr_ready(hdr_ready[1]), .hdr_timestamp(hdr_timestamp),
        .hdr_marker(hdr_marker), .hdr_length(hdr_length), .hdr_field(hdr_field),
        .hdr_line(hdr_line), .hdr_offset(hdr_offset),
        .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]), .s_axis_tlast(s_tlast),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]),
        .stat_pkt_count(stat[1]), .err_len(err_len[1]), .err_oversize(err_ovs[1]));

    function automatic logic [31:0] pb(input logic [7:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    // Reference header word from the descriptor currently on the hdr_* inputs.
    function automatic logic [31:0] hdr_model(input int u, input int idx, input logic [31:0] sq);
        logic [31:0] ssrc;
        ssrc = (u == 0) ? 32'hCAFEF00D : 32'h0;
        case (idx)
            0:       return pb(8'h80, {hdr_marker, 7'd96}, sq[15:8], sq[7:0]);
            1:       return pb(hdr_timestamp[31:24], hdr_timestamp[23:16], hdr_timestamp[15:8], hdr_timestamp[7:0]);
            2:       return pb(ssrc[31:24], ssrc[23:16], ssrc[15:8], ssrc[7:0]);
            3:       return pb(sq[31:24], sq[23:16], hdr_length[15:8], hdr_length[7:0]);
            default: return pb({hdr_field, hdr_line[14:8]}, hdr_line[7:0], {1'b0, hdr_offset[14:8]}, hdr_offset[7:0]);
        endcase
    endfunction

    function automatic logic [31:0] pay(input logic [7:0] salt, input int i);
        return {salt, 8'(i >> 8), 8'(i), ~8'(i)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic push(input int u, input logic [36:0] v);
        if (u == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic mon_unit(input int u);
        logic [36:0] got, exp;
        got = {m_tdata[u], m_tkeep[u], m_tlast[u]};
        if (m_tvalid[u] && m_tready) begin
            checks++;
            if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                errors++;
                $display("FAIL beat_u%0d: got unexpected beat %h, required none", u, got);
            end else begin
                if (u == 0) exp = q0.pop_front();
                else        exp = q1.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL beat_u%0d: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                             u, got[36:5], got[4:1], got[0], exp[36:5], exp[4:1], exp[0]);
                end
            end
        end
        if (err_len[u]) begin
            elen_cnt[u]++;
            checks++;
            if (!tl_prev[u]) begin
                errors++;
                $display("FAIL err_len_timing_u%0d: got pulse without input tlast the cycle before, required pulse only after tlast", u);
            end
        end
        if (err_ovs[u]) eovs_cnt[u]++;
        tl_prev[u] = s_tvalid[u] && s_tready[u] && s_tlast;
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin elen_cnt[u] = 0; eovs_cnt[u] = 0; tl_prev[u] = 0; end
        forever begin
            @(negedge aclk);
            mon_unit(0);
            mon_unit(1);
        end
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish within 1 ms");
        $fatal(1);
    end

    task automatic wait_ready(input int u, input bit hdr, input string name);
        int n;
        n = 0;
        @(negedge aclk);
        while (!(hdr ? hdr_ready[u] : s_tready[u]) && n < BOUND) begin @(negedge aclk); n++; end
        if (!(hdr ? hdr_ready[u] : s_tready[u])) begin
            checks++; errors++;
            $display("FAIL %s_u%0d: got no ready, required ready within %0d cycles", name, u, BOUND);
        end
        @(posedge aclk); #1;
    endtask

    task automatic set_desc(input logic [31:0] ts, input logic m, input logic [15:0] len,
                            input logic f, input logic [14:0] line, input logic [14:0] off);
        hdr_timestamp = ts; hdr_marker = m; hdr_length = len;
        hdr_field = f; hdr_line = line; hdr_offset = off;
    endtask

    // Descriptor must already be set; pushes expected beats, then drives the packet.
    task automatic send_pkt(input int u, input int nw, input logic [3:0] lkeep, input int maxw,
                            input logic [7:0] salt, input bit push_hdr);
        int nout;
        nout = (nw < maxw) ? nw : maxw;
        if (push_hdr)
            for (int i = 0; i < 5; i++) push(u, {hdr_model(u, i, mseq[u]), 4'hF, 1'b0});
        for (int i = 0; i < nout; i++)
            push(u, {pay(salt, i), (i == nw - 1) ? lkeep : 4'hF, (i == nw - 1) || (i == maxw - 1)});
        mseq[u] = mseq[u] + 32'd1;
        hdr_valid[u] = 1'b1;
        wait_ready(u, 1, "hdr_handshake");
        hdr_valid[u] = 1'b0;
        for (int i = 0; i < nw; i++) begin
            s_tdata = pay(salt, i);
            s_tkeep = (i == nw - 1) ? lkeep : 4'hF;
            s_tlast = (i == nw - 1);
            s_tvalid[u] = 1'b1;
            wait_ready(u, 0, "payload_handshake");
        end
        s_tvalid[u] = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic wait_drain(input int u);
        int n;
        n = 0;
        while (((u == 0) ? q0.size() : q1.size()) != 0 && n < BOUND) begin @(posedge aclk); n++; end
        if (((u == 0) ? q0.size() : q1.size()) != 0) begin
            checks++; errors++;
            $display("FAIL drain_u%0d: got %0d beats outstanding, required 0", u, (u == 0) ? q0.size() : q1.size());
            if (u == 0) q0.delete(); else q1.delete();
        end
        repeat (3) @(posedge aclk);
        #1;
    endtask

    initial begin
        int base;
        areset = 1'b1; seq_load = 1'b0; seq_init = '0;
        s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
        for (int u = 0; u < 2; u++) begin hdr_valid[u] = 1'b0; s_tvalid[u] = 1'b0; end
        set_desc(32'h0, 1'b0, 16'h0, 1'b0, 15'h0, 15'h0);
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset_m_tvalid",  {31'b0, m_tvalid[0]},  32'h0);
        chk("reset_hdr_ready", {31'b0, hdr_ready[0]}, 32'h0);
        chk("reset_s_tready",  {31'b0, s_tready[0]},  32'h0);
        chk("reset_stat",      stat[0],               32'h0);
        chk("reset_errs",      {30'b0, err_len[0], err_ovs[0]}, 32'h0);
        @(posedge aclk); #1;
        areset = 1'b0;

        seq_init = 32'h0001FFFE; seq_load = 1'b1;
        @(posedge aclk); #1;
        seq_load = 1'b0;
        mseq[0] = 32'h0001FFFE; mseq[1] = 32'h0001FFFE;

        // Packet 1: hand-computed header words (SSRC CAFEF00D on unit 0).
        set_desc(32'h00000BB8, 1'b0, 16'd8, 1'b0, 15'd5, 15'd0);
        push(0, {32'hFEFF6080, 4'hF, 1'b0});
        push(0, {32'hB80B0000, 4'hF, 1'b0});
        push(0, {32'h0DF0FECA, 4'hF, 1'b0});
        push(0, {32'h08000100, 4'hF, 1'b0});
        push(0, {32'h00000500, 4'hF, 1'b0});
        send_pkt(0, 2, 4'hF, 2231, 8'hA1, 0);
        wait_drain(0);
        chk("p1_err_len", 32'(elen_cnt[0]), 32'd0);
        chk("p1_stat",    stat[0],          32'd1);

        // Packets 2-3: seq 0xFFFF then wrap into ext_seq 2, seq 0.
        set_desc(32'h00001770, 1'b1, 16'd8, 1'b1, 15'h1234, 15'h0567);
        send_pkt(0, 2, 4'hF, 2231, 8'hA2, 1);
        set_desc(32'h12345678, 1'b0, 16'd8, 1'b0, 15'd6, 15'd960);
        send_pkt(0, 2, 4'hF, 2231, 8'hA3, 1);
        wait_drain(0);
        chk("p3_stat", stat[0], 32'd3);

        // 100-word packet, unstalled then with random backpressure.
        set_desc(32'h00002000, 1'b1, 16'd400, 1'b0, 15'd7, 15'd0);
        send_pkt(0, 100, 4'hF, 2231, 8'hB0, 1);
        wait_drain(0);
        bp_en = 1;
        send_pkt(0, 100, 4'hF, 2231, 8'hB0, 1);
        wait_drain(0);
        bp_en = 0;
        @(posedge aclk); #1;
        chk("bp_err_len", 32'(elen_cnt[0]), 32'd0);
        chk("bp_stat",    stat[0],          32'd5);

        // Oversize on the 4-word unit: 6 words in, 9 beats out, 2 drained.
        set_desc(32'h00003000, 1'b0, 16'd24, 1'b0, 15'd1, 15'd0);
        send_pkt(1, 6, 4'hF, 4, 8'hC0, 1);
        wait_drain(1);
        chk("ovs_pulses",  32'(eovs_cnt[1]), 32'd1);
        chk("ovs_err_len", 32'(elen_cnt[1]), 32'd0);
        set_desc(32'h00003100, 1'b0, 16'd12, 1'b0, 15'd2, 15'd0);
        send_pkt(1, 3, 4'hF, 4, 8'hC1, 1);
        wait_drain(1);
        chk("ovs_after_pulses", 32'(eovs_cnt[1]), 32'd1);
        chk("ovs_after_stat",   stat[1],          32'd2);

        // Length check: 4*2+2 = 10 matches, 4*2+1 = 9 does not, empty payload matches 0.
        base = elen_cnt[0];
        set_desc(32'h00004000, 1'b0, 16'd10, 1'b0, 15'd3, 15'd0);
        send_pkt(0, 3, 4'h3, 2231, 8'hD0, 1);
        wait_drain(0);
        chk("len10_ok",  32'(elen_cnt[0] - base), 32'd0);
        send_pkt(0, 3, 4'h1, 2231, 8'hD1, 1);
        wait_drain(0);
        chk("len9_pulse", 32'(elen_cnt[0] - base), 32'd1);
        set_desc(32'h00004100, 1'b0, 16'd0, 1'b0, 15'd4, 15'd0);
        send_pkt(0, 1, 4'h0, 2231, 8'hD2, 1);
        wait_drain(0);
        chk("zero_len_ok", 32'(elen_cnt[0] - base), 32'd1);

        // Reset while payload beat 2 is offered: packet abandoned after beat 1.
        set_desc(32'h00005000, 1'b0, 16'd16, 1'b0, 15'd9, 15'd0);
        for (int i = 0; i < 5; i++) push(0, {hdr_model(0, i, mseq[0]), 4'hF, 1'b0});
        push(0, {pay(8'hE0, 0), 4'hF, 1'b0});
        hdr_valid[0] = 1'b1;
        wait_ready(0, 1, "rst_hdr_handshake");
        hdr_valid[0] = 1'b0;
        s_tdata = pay(8'hE0, 0); s_tkeep = 4'hF; s_tlast = 1'b0; s_tvalid[0] = 1'b1;
        wait_ready(0, 0, "rst_payload_handshake");
        s_tdata = pay(8'hE0, 1);
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0; s_tvalid[0] = 1'b0;
        @(negedge aclk);
        chk("rst_m_tvalid",  {31'b0, m_tvalid[0]},  32'h0);
        chk("rst_hdr_ready", {31'b0, hdr_ready[0]}, 32'h1);
        chk("rst_stat",      stat[0],               32'h0);
        chk("rst_queue",     32'(q0.size()),        32'h0);
        @(posedge aclk); #1;
        mseq[0] = 32'h0; mseq[1] = 32'h0;
        set_desc(32'h00006000, 1'b1, 16'd8, 1'b0, 15'd10, 15'd2);
        send_pkt(0, 2, 4'hF, 2231, 8'hE1, 1);
        wait_drain(0);
        chk("post_rst_stat", stat[0], 32'd1);
        wait_drain(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
